pipe_phy_responder: RTL and testbench
=====================================

# pipe_phy_responder

PHY-side responder for the PIPE interface of the PCIe link layer. It sits opposite the MAC/LTSSM. It answers receiver-detect, PowerDown and Rate requests with PIPE-conformant PhyStatus/RxStatus handshakes, and loops the transmit datapath back onto the receive datapath with one registered cycle of latency. It replaces ad-hoc bench stimulus as the link partner for MAC bring-up and loopback regression.

## Interface
Parameters:
- LANESNUMBER, 16, number of lanes
- MAXPIPEWIDTH, 32, data bits per lane
- DETECT_LAT, 4, cycles from detect request to result report
- PD_LAT, 2, cycles from PowerDown change to PhyStatus pulse
- RATE_LAT, 8, cycles from Rate change to PhyStatus pulse
- RESET_LAT, 3, cycles PhyStatus stays high after reset deasserts

Ports:
- CLK  in  1  single clock
- reset  in  1  synchronous, active-high
- TxData  in  MAXPIPEWIDTH*LANESNUMBER  MAC transmit data
- TxDataValid  in  LANESNUMBER  per-lane data valid
- TxDataK  in  (MAXPIPEWIDTH/8)*LANESNUMBER  K-symbol flags
- TxElecIdle  in  LANESNUMBER  transmitter electrical idle
- TxDetectRx_Loopback  in  LANESNUMBER  detect request (in P1) or loopback
- PowerDown  in  4*LANESNUMBER  power state; the lane 0 field governs all lanes
- Rate  in  4  link rate
- rx_present  in  LANESNUMBER  bench-set mask of lanes with a far-end receiver
- RxData  out  MAXPIPEWIDTH*LANESNUMBER  looped receive data
- RxDataValid  out  LANESNUMBER  looped data valid
- RxDataK  out  (MAXPIPEWIDTH/8)*LANESNUMBER  looped K flags
- RxValid  out  LANESNUMBER  symbol lock / valid
- RxElectricalIdle  out  LANESNUMBER  receiver idle indication
- RxStatus  out  3*LANESNUMBER  per-lane status
- PhyStatus  out  LANESNUMBER  handshake/ready (all lanes identical)

## Operation
- FSM states: RST_HOLD, IDLE, DETECT, CHANGE, REPORT. An 8-bit down-counter times every state.
- RST_HOLD:
  - Entered while reset is high. PhyStatus is all-ones during reset.
  - After reset falls, the counter runs RESET_LAT cycles, then PhyStatus drops to 0 and the FSM enters IDLE.
- IDLE, detect request:
  - Condition: any TxDetectRx_Loopback bit set, the matching TxElecIdle bit high, and PowerDown[3:0]==4'd2 (P1).
  - Capture the requesting lane mask and go to DETECT with counter = DETECT_LAT-1.
- IDLE, power/rate change:
  - Condition: PowerDown[3:0] or Rate differs from its registered previous value.
  - Go to CHANGE. The counter is PD_LAT-1 if only PowerDown changed. It is RATE_LAT-1 if Rate changed, including when both changed in the same cycle; that case produces one handshake.
  - Update the registered previous values on capture.
- Priority in IDLE: detect over change.
- Changes that occur outside IDLE are not lost. The previous-value compare re-fires in IDLE, after REPORT.
- A detect request outside IDLE is ignored. The MAC must hold it until PhyStatus.
- DETECT expiry to REPORT:
  - PhyStatus = all-ones for exactly 1 cycle.
  - RxStatus = 3'b011 for requesting lanes with rx_present=1. All other lanes get 3'b000.
- CHANGE expiry to REPORT: PhyStatus pulses 1 cycle, RxStatus = 0.
- REPORT always returns to IDLE the next cycle. Minimum 1 IDLE cycle separates handshakes.
- Loopback (always active, independent of the FSM), registered 1 cycle per lane:
  - RxData ← TxData, RxDataK ← TxDataK.
  - RxDataValid ← TxDataValid & ~TxElecIdle.
  - RxValid ← ~TxElecIdle.
  - RxElectricalIdle ← TxElecIdle.
- Reset mid-handshake aborts it. The FSM returns to RST_HOLD with no REPORT pulse, and the previous-value registers reload from the current inputs.

## Timing
- Reset values:
  - PhyStatus all-ones.
  - RxStatus 0, RxData 0, RxDataK 0, RxDataValid 0, RxValid 0.
  - RxElectricalIdle all-ones.
- Detect request sampled at edge N: PhyStatus/RxStatus high at edge N+DETECT_LAT+1, for one cycle.
- PowerDown-only change at edge N: pulse at N+PD_LAT+1. Rate change: pulse at N+RATE_LAT+1.
- Loopback latency is exactly 1 cycle.
- All outputs are registered. No combinational input-to-output paths.

## Configuration
- PIPE_PHY_ERR_INJECT_EN defined: adds input err_inject [LANESNUMBER-1:0]. For each set lane, the looped RxData bit 0 is inverted on that cycle, and RxStatus is 3'b100 (decode error) for one cycle unless a REPORT is driving it.
- Undefined: port absent, loopback is bit-exact, and RxStatus carries only handshake results.

## Test plan
- Reset release: reset high 5 cycles, then low → PhyStatus=16'hFFFF for 3 more cycles, then 0; RxElectricalIdle=16'hFFFF.
- Detect: PowerDown=4'd2, TxElecIdle=all-ones, TxDetectRx_Loopback=16'hFFFF, rx_present=16'h00FF → after 5 cycles, 1-cycle PhyStatus=16'hFFFF, RxStatus lanes 0-7 = 3'b011, lanes 8-15 = 3'b000.
- Simultaneous change: PowerDown 4'd2→4'd0 and Rate 0→1 in the same cycle → exactly one PhyStatus pulse, 9 cycles later.
- Loopback: TxElecIdle=0, TxDataValid=all-ones, random TxData and TxDataK → RxData/RxDataK equal the previous-cycle inputs and RxValid=16'hFFFF, checked every cycle for 1000 cycles.
- Reset mid-DETECT: assert reset 2 cycles after the detect request → no RxStatus=3'b011 pulse; PhyStatus stays high through reset plus 3 cycles.
- With PIPE_PHY_ERR_INJECT_EN: err_inject=16'h0001 for one cycle → next cycle RxData[0]=~TxData[0] and RxStatus[2:0]=3'b100.

Source files
------------

// File: rtl/pipe_phy_responder.sv
// pipe_phy_responder: PHY-side link partner for the PIPE interface.
// Answers receiver-detect, PowerDown and Rate requests with PhyStatus/RxStatus
// handshakes and loops the transmit datapath back onto the receive datapath
// with one registered cycle of latency.
// Optional feature macro: PIPE_PHY_ERR_INJECT_EN adds the err_inject input,
// which flips looped RxData bit 0 and reports a decode error on RxStatus.
module pipe_phy_responder #(
  parameter int LANESNUMBER  = 16,
  parameter int MAXPIPEWIDTH = 32,
  parameter int DETECT_LAT   = 4,
  parameter int PD_LAT       = 2,
  parameter int RATE_LAT     = 8,
  parameter int RESET_LAT    = 3
) (
  input  logic                                     CLK,
  input  logic                                     reset,
  input  logic [MAXPIPEWIDTH*LANESNUMBER-1:0]      TxData,
  input  logic [LANESNUMBER-1:0]                   TxDataValid,
  input  logic [(MAXPIPEWIDTH/8)*LANESNUMBER-1:0]  TxDataK,
  input  logic [LANESNUMBER-1:0]                   TxElecIdle,
  input  logic [LANESNUMBER-1:0]                   TxDetectRx_Loopback,
  input  logic [4*LANESNUMBER-1:0]                 PowerDown,
  input  logic [3:0]                               Rate,
  input  logic [LANESNUMBER-1:0]                   rx_present,
  output logic [MAXPIPEWIDTH*LANESNUMBER-1:0]      RxData,
  output logic [LANESNUMBER-1:0]                   RxDataValid,
  output logic [(MAXPIPEWIDTH/8)*LANESNUMBER-1:0]  RxDataK,
  output logic [LANESNUMBER-1:0]                   RxValid,
  output logic [LANESNUMBER-1:0]                   RxElectricalIdle,
  output logic [3*LANESNUMBER-1:0]                 RxStatus,
  output logic [LANESNUMBER-1:0]                   PhyStatus
`ifdef PIPE_PHY_ERR_INJECT_EN
  ,
  input  logic [LANESNUMBER-1:0]                   err_inject
`endif
);

  localparam int DW = MAXPIPEWIDTH * LANESNUMBER;
  localparam int KW = (MAXPIPEWIDTH / 8) * LANESNUMBER;

  // Counter reload values: a state lasts reload+1 cycles before expiring.
  localparam logic [7:0] RST_CNT  = 8'(RESET_LAT - 1);
  localparam logic [7:0] DET_CNT  = 8'(DETECT_LAT - 1);
  localparam logic [7:0] PD_CNT   = 8'(PD_LAT - 1);
  localparam logic [7:0] RATE_CNT = 8'(RATE_LAT - 1);

  localparam logic [3:0] PD_P1 = 4'd2;

  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    IDLE     = 3'd1,
    DETECT   = 3'd2,
    CHANGE   = 3'd3,
    REPORT   = 3'd4
  } stateT;

  stateT                   state, stateNext;
  logic [7:0]              cnt, cntNext;
  logic [LANESNUMBER-1:0]  detMask, detMaskNext;
  logic [LANESNUMBER-1:0]  rptMask, rptMaskNext;
  logic [3:0]              prevPd, prevPdNext;
  logic [3:0]              prevRate, prevRateNext;
  logic [LANESNUMBER-1:0]  phyNext;
  logic [3*LANESNUMBER-1:0] rxStatusNext;

  logic [3:0]              pd0;
  logic [LANESNUMBER-1:0]  detLanes;
  logic                    detReq;
  logic                    pdChg;
  logic                    rateChg;
  logic                    unusedPdFields;

  // Lane 0 PowerDown governs every lane; the other lane fields are ignored.
  assign pd0            = PowerDown[3:0];
  assign unusedPdFields = ^PowerDown[4*LANESNUMBER-1:4];
  assign detLanes       = TxDetectRx_Loopback & TxElecIdle;
  assign detReq         = (|detLanes) && (pd0 == PD_P1);
  assign pdChg          = (pd0 != prevPd);
  assign rateChg        = (Rate != prevRate);

  logic [LANESNUMBER-1:0] errLanes;
  logic [DW-1:0]          errMask;
`ifdef PIPE_PHY_ERR_INJECT_EN
  assign errLanes = err_inject;
  // Error injection only touches bit 0 of each lane's looped data.
  always_comb begin
    errMask = '0;
    for (int l = 0; l < LANESNUMBER; l++) begin
      errMask[l*MAXPIPEWIDTH] = err_inject[l];
    end
  end
`else
  assign errLanes = '0;
  assign errMask  = '0;
`endif

  // Handshake FSM state and captured request context.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= RST_HOLD;
      cnt       <= RST_CNT;
      detMask   <= '0;
      rptMask   <= '0;
      prevPd    <= pd0;
      prevRate  <= Rate;
      PhyStatus <= '1;
      RxStatus  <= '0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      detMask   <= detMaskNext;
      rptMask   <= rptMaskNext;
      prevPd    <= prevPdNext;
      prevRate  <= prevRateNext;
      PhyStatus <= phyNext;
      RxStatus  <= rxStatusNext;
    end
  end

  // Next-state, counter and registered-output decode.
  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    detMaskNext  = detMask;
    rptMaskNext  = rptMask;
    prevPdNext   = prevPd;
    prevRateNext = prevRate;
    phyNext      = '0;
    rxStatusNext = '0;

    case (state)
      RST_HOLD: begin
        if (cnt == 8'd0) stateNext = IDLE;
        else             cntNext   = cnt - 8'd1;
      end
      IDLE: begin
        // Detect wins; a pending change is picked up once we return here.
        if (detReq) begin
          stateNext   = DETECT;
          cntNext     = DET_CNT;
          detMaskNext = detLanes;
        end else if (pdChg || rateChg) begin
          stateNext    = CHANGE;
          cntNext      = rateChg ? RATE_CNT : PD_CNT;
          prevPdNext   = pd0;
          prevRateNext = Rate;
        end
      end
      DETECT: begin
        if (cnt == 8'd0) begin
          stateNext   = REPORT;
          rptMaskNext = detMask & rx_present;
        end else begin
          cntNext = cnt - 8'd1;
        end
      end
      CHANGE: begin
        if (cnt == 8'd0) begin
          stateNext   = REPORT;
          rptMaskNext = '0;
        end else begin
          cntNext = cnt - 8'd1;
        end
      end
      REPORT:  stateNext = IDLE;
      default: stateNext = RST_HOLD;
    endcase

    // Outputs lag the state by one register so the pulse lands one cycle
    // after the counter expires.
    if (state == RST_HOLD || state == REPORT) phyNext = '1;

    for (int l = 0; l < LANESNUMBER; l++) begin
      if (state == REPORT)
        rxStatusNext[3*l +: 3] = rptMask[l] ? 3'b011 : 3'b000;
      else if (errLanes[l])
        rxStatusNext[3*l +: 3] = 3'b100;
    end
  end

  // Loopback path: one registered cycle from Tx to Rx, independent of the FSM.
  always_ff @(posedge CLK) begin
    if (reset) begin
      RxData           <= '0;
      RxDataK          <= '0;
      RxDataValid      <= '0;
      RxValid          <= '0;
      RxElectricalIdle <= '1;
    end else begin
      RxData           <= TxData ^ errMask;
      RxDataK          <= TxDataK;
      RxDataValid      <= TxDataValid & ~TxElecIdle;
      RxValid          <= ~TxElecIdle;
      RxElectricalIdle <= TxElecIdle;
    end
  end

  logic [KW-1:0] unusedKw;
  assign unusedKw = '0;

endmodule

// File: tb/tb_pipe_phy_responder.sv
// Directed testbench for pipe_phy_responder (default parameters).
module tb_pipe_phy_responder;

  localparam int L  = 16;
  localparam int W  = 32;
  localparam int DW = W * L;
  localparam int KW = (W / 8) * L;

  logic            CLK = 1'b0;
  logic            reset;
  logic [DW-1:0]   TxData;
  logic [L-1:0]    TxDataValid;
  logic [KW-1:0]   TxDataK;
  logic [L-1:0]    TxElecIdle;
  logic [L-1:0]    TxDetectRx_Loopback;
  logic [4*L-1:0]  PowerDown;
  logic [3:0]      Rate;
  logic [L-1:0]    rx_present;
  logic [DW-1:0]   RxData;
  logic [L-1:0]    RxDataValid;
  logic [KW-1:0]   RxDataK;
  logic [L-1:0]    RxValid;
  logic [L-1:0]    RxElectricalIdle;
  logic [3*L-1:0]  RxStatus;
  logic [L-1:0]    PhyStatus;
`ifdef PIPE_PHY_ERR_INJECT_EN
  logic [L-1:0]    err_inject;
`endif

  int checks = 0;
  int errors = 0;

  pipe_phy_responder dut (
    .CLK                 (CLK),
    .reset               (reset),
    .TxData              (TxData),
    .TxDataValid         (TxDataValid),
    .TxDataK             (TxDataK),
    .TxElecIdle          (TxElecIdle),
    .TxDetectRx_Loopback (TxDetectRx_Loopback),
    .PowerDown           (PowerDown),
    .Rate                (Rate),
    .rx_present          (rx_present),
    .RxData              (RxData),
    .RxDataValid         (RxDataValid),
    .RxDataK             (RxDataK),
    .RxValid             (RxValid),
    .RxElectricalIdle    (RxElectricalIdle),
    .RxStatus            (RxStatus),
    .PhyStatus           (PhyStatus)
`ifdef PIPE_PHY_ERR_INJECT_EN
    ,
    .err_inject          (err_inject)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randTx(output logic [DW-1:0] d, output logic [KW-1:0] k);
    for (int l = 0; l < L; l++) d[W*l +: W] = $urandom();
    for (int j = 0; j < KW / 32; j++) k[32*j +: 32] = $urandom();
  endtask

  logic [DW-1:0]  expData;
  logic [KW-1:0]  expK;
  logic [3*L-1:0] detStatus;

  initial begin
    detStatus = {24'h0, {8{3'b011}}};

    reset               = 1'b1;
    TxData              = '0;
    TxDataValid         = '0;
    TxDataK             = '0;
    TxElecIdle          = '1;
    TxDetectRx_Loopback = '0;
    PowerDown           = {L{4'd2}};
    Rate                = 4'd0;
    rx_present          = 16'h00FF;
`ifdef PIPE_PHY_ERR_INJECT_EN
    err_inject          = '0;
`endif

    // Reset held for 5 edges
    for (int i = 0; i < 5; i++) tick();
    chk("rst_phy",      PhyStatus, 16'hFFFF);
    chk("rst_rxstatus", RxStatus, '0);
    chk("rst_rxdata",   RxData, '0);
    chk("rst_rxdatak",  RxDataK, '0);
    chk("rst_rxdv",     RxDataValid, '0);
    chk("rst_rxvalid",  RxValid, '0);
    chk("rst_eidle",    RxElectricalIdle, 16'hFFFF);

    // Release: PhyStatus high 3 more cycles, then low
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rel_phy_hi", PhyStatus, 16'hFFFF);
    end
    tick();
    chk("rel_phy_lo", PhyStatus, '0);
    chk("rel_eidle",  RxElectricalIdle, 16'hFFFF);

    // Receiver detect in P1, far end present on lanes 0-7
    TxDetectRx_Loopback = 16'hFFFF;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("det_wait_phy", PhyStatus, '0);
      chk("det_wait_st",  RxStatus, '0);
    end
    tick();
    chk("det_phy",    PhyStatus, 16'hFFFF);
    chk("det_status", RxStatus, detStatus);
    TxDetectRx_Loopback = '0;
    tick();
    chk("det_phy_end",    PhyStatus, '0);
    chk("det_status_end", RxStatus, '0);

    // Simultaneous PowerDown P1->P0 and Rate 0->1: one pulse at +9
    PowerDown = {L{4'd0}};
    Rate      = 4'd1;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("chg_wait_phy", PhyStatus, '0);
    end
    tick();
    chk("chg_phy",    PhyStatus, 16'hFFFF);
    chk("chg_status", RxStatus, '0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("chg_single_pulse", PhyStatus, '0);
    end

    // PowerDown-only change P0->P1: pulse at +3
    PowerDown = {L{4'd2}};
    tick();
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("pd_wait_phy", PhyStatus, '0);
    end
    tick();
    chk("pd_phy", PhyStatus, 16'hFFFF);
    tick();
    chk("pd_phy_end", PhyStatus, '0);

    // Partial electrical idle gating of the loopback
    TxElecIdle  = 16'h00F0;
    TxDataValid = 16'hFFFF;
    tick();
    chk("part_rxdv",   RxDataValid, 16'hFF0F);
    chk("part_rxval",  RxValid, 16'hFF0F);
    chk("part_eidle",  RxElectricalIdle, 16'h00F0);

    // Random loopback traffic, checked every cycle
    TxElecIdle = '0;
    for (int i = 0; i < 1000; i++) begin
      randTx(expData, expK);
      TxData  = expData;
      TxDataK = expK;
      tick();
      chk("lb_data",  RxData, expData);
      chk("lb_k",     RxDataK, expK);
      chk("lb_valid", RxValid, 16'hFFFF);
      chk("lb_dv",    RxDataValid, 16'hFFFF);
    end
    chk("lb_eidle", RxElectricalIdle, '0);

    // Reset two cycles after a detect request aborts it
    TxElecIdle          = '1;
    TxDataValid         = '0;
    TxDetectRx_Loopback = 16'hFFFF;
    tick();
    tick();
    reset               = 1'b1;
    TxDetectRx_Loopback = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("mid_rst_phy", PhyStatus, 16'hFFFF);
      chk("mid_rst_st",  RxStatus, '0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_rel_phy", PhyStatus, 16'hFFFF);
      chk("mid_rel_st",  RxStatus, '0);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mid_after_phy", PhyStatus, '0);
      chk("mid_after_st",  RxStatus, '0);
    end

`ifdef PIPE_PHY_ERR_INJECT_EN
    // Single-cycle error injection on lane 0
    TxElecIdle = '0;
    randTx(expData, expK);
    TxData     = expData;
    TxDataK    = expK;
    err_inject = 16'h0001;
    tick();
    chk("err_bit0",   RxData[0], ~expData[0]);
    chk("err_rest",   RxData[DW-1:1], expData[DW-1:1]);
    chk("err_status", RxStatus, {45'h0, 3'b100});
    err_inject = '0;
    tick();
    chk("err_clear_data",   RxData, expData);
    chk("err_clear_status", RxStatus, '0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
